// File: rtl/lsq_param.sv
// In-order load/store queue with operand wake-up and a single
// outstanding memory request issued from the head entry.
module lsq_param #(
  parameter int DEPTH_BIT = 3,
  parameter int ROB_BIT   = 4,
  parameter int NUM_CDB   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_r1,
  input  logic [31:0]                in_r2,
  input  logic                       in_has_dep1,
  input  logic                       in_has_dep2,
  input  logic [ROB_BIT-1:0]         in_dep1,
  input  logic [ROB_BIT-1:0]         in_dep2,
  input  logic [11:0]                in_offset,
  input  logic [ROB_BIT-1:0]         in_rob_id,
  input  logic [3:0]                 in_type,
  output logic                       full,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_BIT-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]      cdb_value,
  input  logic                       rob_empty,
  input  logic [ROB_BIT-1:0]         rob_head_id,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [2:0]                 mem_size,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_ready,
  input  logic [31:0]                mem_rdata,
  output logic                       out_valid,
  output logic [ROB_BIT-1:0]         out_rob_id,
  output logic [31:0]                out_value
);

  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam logic [DEPTH_BIT:0] FULL_LVL = (DEPTH_BIT+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t state_q;

  logic [DEPTH-1:0]   vld_q;
  logic [DEPTH-1:0]   hd1_q;
  logic [DEPTH-1:0]   hd2_q;
  logic [31:0]        r1_q  [DEPTH];
  logic [31:0]        r2_q  [DEPTH];
  logic [ROB_BIT-1:0] dep1_q[DEPTH];
  logic [ROB_BIT-1:0] dep2_q[DEPTH];
  logic [11:0]        off_q [DEPTH];
  logic [ROB_BIT-1:0] tag_q [DEPTH];
  logic [3:0]         typ_q [DEPTH];

  logic [DEPTH_BIT-1:0] head_q, head_d;
  logic [DEPTH_BIT-1:0] tail_q, tail_d;
  logic [DEPTH_BIT:0]   count_q, count_d;
  logic                 full_q, full_d;

  logic               mem_req_q;
  logic               mem_we_q;
  logic [2:0]         mem_size_q;
  logic [31:0]        mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               out_valid_q;
  logic [ROB_BIT-1:0] out_rob_id_q;
  logic [31:0]        out_value_q;

  // Returns {hit, value}; later writes win, so channel 0 beats the rest
  // and our own result pulse is the lowest-priority source.
  function automatic logic [32:0] bcast(
    input logic [ROB_BIT-1:0]         tag,
    input logic [NUM_CDB-1:0]         v,
    input logic [NUM_CDB*ROB_BIT-1:0] ids,
    input logic [NUM_CDB*32-1:0]      vals,
    input logic                       ov,
    input logic [ROB_BIT-1:0]         oid,
    input logic [31:0]                oval
  );
    logic [32:0] r;
    r = '0;
    if (ov && oid == tag) r = {1'b1, oval};
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (v[i] && ids[i*ROB_BIT +: ROB_BIT] == tag)
        r = {1'b1, vals[i*32 +: 32]};
    end
    return r;
  endfunction

  logic [32:0]      w1 [DEPTH];
  logic [32:0]      w2 [DEPTH];
  logic [DEPTH-1:0] w1_hit;
  logic [DEPTH-1:0] w2_hit;
  logic [32:0]      bp1;
  logic [32:0]      bp2;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w1[i] = bcast(dep1_q[i], cdb_valid, cdb_rob_id, cdb_value,
                    out_valid_q, out_rob_id_q, out_value_q);
      w2[i] = bcast(dep2_q[i], cdb_valid, cdb_rob_id, cdb_value,
                    out_valid_q, out_rob_id_q, out_value_q);
      w1_hit[i] = w1[i][32] & vld_q[i] & hd1_q[i];
      w2_hit[i] = w2[i][32] & vld_q[i] & hd2_q[i];
    end
    bp1 = bcast(in_dep1, cdb_valid, cdb_rob_id, cdb_value,
                out_valid_q, out_rob_id_q, out_value_q);
    bp2 = bcast(in_dep2, cdb_valid, cdb_rob_id, cdb_value,
                out_valid_q, out_rob_id_q, out_value_q);
  end

  logic               h_vld;
  logic               h_rdy;
  logic [3:0]         h_typ;
  logic [ROB_BIT-1:0] h_tag;
  logic [31:0]        h_addr;
  logic               push;
  logic               pop;
  logic               issue;

  assign h_vld  = vld_q[head_q];
  assign h_rdy  = !hd1_q[head_q] && !hd2_q[head_q];
  assign h_typ  = typ_q[head_q];
  assign h_tag  = tag_q[head_q];
  assign h_addr = r1_q[head_q] + {{20{off_q[head_q][11]}}, off_q[head_q]};

  assign push  = in_valid && !full_q && !flush;
  assign pop   = (state_q == BUSY) && mem_ready && !flush;
  assign issue = (state_q == IDLE) && h_vld && h_rdy && !flush &&
                 (!h_typ[0] || (!rob_empty && h_tag == rob_head_id));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    full_d = (count_d >= FULL_LVL);
  end

  logic [31:0] ld_val;

  always_comb begin
    unique case (mem_size_q)
      3'b000:  ld_val = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  ld_val = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  ld_val = {24'h0, mem_rdata[7:0]};
      3'b101:  ld_val = {16'h0, mem_rdata[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      hd1_q        <= '0;
      hd2_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_size_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      out_valid_q  <= 1'b0;
      out_rob_id_q <= '0;
      out_value_q  <= '0;
    end else if (rdy) begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      full_q      <= full_d;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w1_hit[i]) hd1_q[i] <= 1'b0;
        if (w2_hit[i]) hd2_q[i] <= 1'b0;
      end
      if (flush) begin
        vld_q <= '0;
        hd1_q <= '0;
        hd2_q <= '0;
      end else begin
        if (pop) vld_q[head_q] <= 1'b0;
        if (push) begin
          vld_q[tail_q] <= 1'b1;
          hd1_q[tail_q] <= in_has_dep1 && !bp1[32];
          hd2_q[tail_q] <= in_has_dep2 && !bp2[32];
        end
      end
      unique case (state_q)
        IDLE: begin
          if (issue) begin
            state_q     <= BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= h_typ[0];
            mem_size_q  <= h_typ[3:1];
            mem_addr_q  <= h_addr;
            mem_wdata_q <= h_typ[0] ? r2_q[head_q] : 32'h0;
          end
        end
        BUSY: begin
          // A flush coinciding with completion has nothing left to drain.
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            if (!flush) begin
              out_valid_q  <= 1'b1;
              out_rob_id_q <= h_tag;
              out_value_q  <= mem_we_q ? 32'h0 : ld_val;
            end
          end else if (flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w1_hit[i]) r1_q[i] <= w1[i][31:0];
        if (w2_hit[i]) r2_q[i] <= w2[i][31:0];
      end
      if (push) begin
        r1_q[tail_q]   <= (in_has_dep1 && bp1[32]) ? bp1[31:0] : in_r1;
        r2_q[tail_q]   <= (in_has_dep2 && bp2[32]) ? bp2[31:0] : in_r2;
        dep1_q[tail_q] <= in_dep1;
        dep2_q[tail_q] <= in_dep2;
        off_q[tail_q]  <= in_offset;
        tag_q[tail_q]  <= in_rob_id;
        typ_q[tail_q]  <= in_type;
      end
    end
  end

  assign full       = full_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_size   = mem_size_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign out_valid  = out_valid_q;
  assign out_rob_id = out_rob_id_q;
  assign out_value  = out_value_q;

endmodule

// File: tb/tb_lsq_param.sv
// Directed bench for lsq_param: load/store issue, wake-up, full/wrap,
// flush drain and reset abandonment.
module tb_lsq_param;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_r1;
  logic [31:0] in_r2;
  logic        in_has_dep1;
  logic        in_has_dep2;
  logic [3:0]  in_dep1;
  logic [3:0]  in_dep2;
  logic [11:0] in_offset;
  logic [3:0]  in_rob_id;
  logic [3:0]  in_type;
  logic        full;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_value;
  logic        rob_empty;
  logic [3:0]  rob_head_id;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [3:0]  out_rob_id;
  logic [31:0] out_value;

  int tests;
  int fails;

  lsq_param dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_r1(in_r1), .in_r2(in_r2),
    .in_has_dep1(in_has_dep1), .in_has_dep2(in_has_dep2),
    .in_dep1(in_dep1), .in_dep2(in_dep2),
    .in_offset(in_offset), .in_rob_id(in_rob_id), .in_type(in_type),
    .full(full), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_value(cdb_value), .rob_empty(rob_empty),
    .rob_head_id(rob_head_id), .mem_req(mem_req), .mem_we(mem_we),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_rob_id(out_rob_id),
    .out_value(out_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [3:0] typ, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [11:0] off,
                      input logic [3:0] tag, input logic hd1,
                      input logic [3:0] d1);
    in_valid    = 1'b1;
    in_type     = typ;
    in_r1       = r1;
    in_r2       = r2;
    in_offset   = off;
    in_rob_id   = tag;
    in_has_dep1 = hd1;
    in_dep1     = d1;
    in_has_dep2 = 1'b0;
    in_dep2     = 4'h0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_r1 = '0; in_r2 = '0; in_has_dep1 = 1'b0; in_has_dep2 = 1'b0;
    in_dep1 = '0; in_dep2 = '0; in_offset = '0; in_rob_id = '0;
    in_type = '0; cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
    rob_empty = 1'b1; rob_head_id = '0; mem_ready = 1'b0;
    mem_rdata = '0;
    tick(); tick();
    check("rst_full", 32'(full), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_oval", 32'(out_valid), 32'h0);
    check("rst_oval_v", out_value, 32'h0);
    rst = 1'b0;
    tick();

    // byte load, negative offset, sign-extended result
    disp(4'b0000, 32'h1000, 32'h0, 12'hFFC, 4'd3, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check("ld_req", 32'(mem_req), 32'h1);
    check("ld_addr", mem_addr, 32'h0000_0FFC);
    check("ld_size", 32'(mem_size), 32'h0);
    check("ld_we", 32'(mem_we), 32'h0);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0080;
    tick();
    mem_ready = 1'b0;
    check("ld_ov", 32'(out_valid), 32'h1);
    check("ld_tag", 32'(out_rob_id), 32'h3);
    check("ld_val", out_value, 32'hFFFF_FF80);
    check("ld_req_off", 32'(mem_req), 32'h0);
    tick();
    check("ld_pulse", 32'(out_valid), 32'h0);

    // store waits for ROB head
    rob_empty = 1'b0; rob_head_id = 4'd4;
    disp(4'b0101, 32'h200, 32'hDEAD_BEEF, 12'h008, 4'd5, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("st_gate", 32'(mem_req), 32'h0);
    rob_head_id = 4'd5;
    tick();
    check("st_req", 32'(mem_req), 32'h1);
    check("st_we", 32'(mem_we), 32'h1);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_addr", mem_addr, 32'h208);
    check("st_size", 32'(mem_size), 32'h2);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0;
    check("st_ov", 32'(out_valid), 32'h1);
    check("st_tag", 32'(out_rob_id), 32'h5);
    check("st_val", out_value, 32'h0);
    tick();

    // dispatch-cycle bypass from cdb channel 1
    disp(4'b0100, 32'h5555, 32'h0, 12'h004, 4'd8, 1'b1, 4'd7);
    cdb_valid = 2'b10; cdb_rob_id = {4'd7, 4'd0};
    cdb_value = {32'h2000, 32'h0};
    tick();
    in_valid = 1'b0; cdb_valid = 2'b00;
    tick();
    check("bp_addr", mem_addr, 32'h2004);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0;
    check("bp_val", out_value, 32'h1234_5678);
    check("bp_tag", 32'(out_rob_id), 32'h8);
    tick();

    // later wake-up
    disp(4'b0100, 32'h5555, 32'h0, 12'h004, 4'd9, 1'b1, 4'd7);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("wk_wait", 32'(mem_req), 32'h0);
    cdb_valid = 2'b10; cdb_rob_id = {4'd7, 4'd0};
    cdb_value = {32'h2000, 32'h0};
    tick();
    cdb_valid = 2'b00;
    tick();
    check("wk_req", 32'(mem_req), 32'h1);
    check("wk_addr", mem_addr, 32'h2004);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();

    // duplicate tag: channel 0 wins
    disp(4'b0100, 32'h5555, 32'h0, 12'h004, 4'd10, 1'b1, 4'd6);
    cdb_valid = 2'b11; cdb_rob_id = {4'd6, 4'd6};
    cdb_value = {32'h4000, 32'h3000};
    tick();
    in_valid = 1'b0; cdb_valid = 2'b00;
    tick();
    check("dup_addr", mem_addr, 32'h3004);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();

    // fill to DEPTH-1 with no completions, wrapping pointers
    for (int k = 0; k < 7; k++) begin
      disp(4'b1000, 32'((k + 1) * 256), 32'h0, 12'h000, 4'(k), 1'b0, 4'd0);
      tick();
      if (k == 5) check("full_lo", 32'(full), 32'h0);
    end
    check("full_hi", 32'(full), 32'h1);
    disp(4'b1000, 32'h9999, 32'h0, 12'h000, 4'd7, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    check("full_hold", 32'(full), 32'h1);
    for (int k = 0; k < 7; k++) begin
      check("drn_req", 32'(mem_req), 32'h1);
      check("drn_addr", mem_addr, 32'((k + 1) * 256));
      mem_ready = 1'b1; mem_rdata = {24'hABCDEF, 8'(8'h80 + k)};
      tick();
      mem_ready = 1'b0;
      check("drn_tag", 32'(out_rob_id), 32'(k));
      check("drn_val", out_value, 32'(8'h80 + k));
      if (k == 0) check("full_clr", 32'(full), 32'h0);
      tick();
    end
    check("drn_empty", 32'(mem_req), 32'h0);

    // refill after wrap, most-negative offset
    disp(4'b0100, 32'h1000, 32'h0, 12'h800, 4'd11, 1'b0, 4'd0);
    tick();
    disp(4'b0100, 32'h600, 32'h0, 12'h7FF, 4'd12, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    check("wr_addr0", mem_addr, 32'h800);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("wr_tag0", 32'(out_rob_id), 32'd11);
    tick();
    check("wr_addr1", mem_addr, 32'hDFF);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("wr_tag1", 32'(out_rob_id), 32'd12);
    tick();

    // flush while busy: drain, discard
    disp(4'b0100, 32'h40, 32'h0, 12'h000, 4'd2, 1'b0, 4'd0);
    tick();
    disp(4'b0100, 32'h44, 32'h0, 12'h000, 4'd4, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    check("fl_req", 32'(mem_req), 32'h1);
    check("fl_addr", mem_addr, 32'h40);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_full", 32'(full), 32'h0);
    check("fl_drain", 32'(mem_req), 32'h1);
    tick(); tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("fl_noout", 32'(out_valid), 32'h0);
    check("fl_idle", 32'(mem_req), 32'h0);
    tick();
    check("fl_empty", 32'(mem_req), 32'h0);
    disp(4'b0100, 32'h80, 32'h0, 12'h000, 4'd6, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check("fl_next", mem_addr, 32'h80);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("fl_next_tag", 32'(out_rob_id), 32'd6);
    check("fl_next_ov", 32'(out_valid), 32'h1);
    tick();

    // reset mid-transaction, stray mem_ready ignored
    disp(4'b0100, 32'hC0, 32'h0, 12'h000, 4'd1, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check("rs_busy", 32'(mem_req), 32'h1);
    rst = 1'b1;
    #1;
    check("rs_async", 32'(mem_req), 32'h0);
    check("rs_addr", mem_addr, 32'h0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("rs_stray", 32'(out_valid), 32'h0);
    check("rs_idle", 32'(mem_req), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
